// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: types and default geometry shared by the refill path and the data RAM controller
package hpdcache_pkg;
    typedef int unsigned hpdcache_uint;

    localparam hpdcache_uint HPDCACHE_SETS          = 128;
    localparam hpdcache_uint HPDCACHE_WAYS          = 4;
    localparam hpdcache_uint HPDCACHE_LINE_WIDTH    = 512;
    localparam hpdcache_uint HPDCACHE_REFILL_WIDTH  = 128;
    localparam hpdcache_uint HPDCACHE_REFILL_CHUNKS = HPDCACHE_LINE_WIDTH / HPDCACHE_REFILL_WIDTH;

    typedef logic [$clog2(HPDCACHE_SETS)-1:0] hpdcache_set_t;
    typedef logic [HPDCACHE_WAYS-1:0]         hpdcache_way_vector_t;
    typedef logic [(HPDCACHE_REFILL_CHUNKS > 1 ? $clog2(HPDCACHE_REFILL_CHUNKS) : 1)-1:0]
        hpdcache_refill_chunk_idx_t;
endpackage

// File: rtl/hpdcache_refill_line_writer.sv
// hpdcache_refill_line_writer: pops one assembled refill line and writes it
// into the data RAM chunk by chunk, then reports completion.
//   req_*   : target set/way from the miss handler (accepted in IDLE only)
//   line_*  : upsize buffer read side (valid, pop, head data)
//   ram_*   : chunk write request with grant handshake; held stable until granted
//   done_*  : completion notice, held until done_ready_i
module hpdcache_refill_line_writer
    import hpdcache_pkg::*;
#(
    parameter hpdcache_uint LINE_WIDTH  = HPDCACHE_LINE_WIDTH,
    parameter hpdcache_uint CHUNK_WIDTH = HPDCACHE_REFILL_WIDTH,
    parameter hpdcache_uint SETS        = HPDCACHE_SETS,
    parameter hpdcache_uint WAYS        = HPDCACHE_WAYS,
    parameter hpdcache_uint SET_W       = $clog2(SETS),
    parameter hpdcache_uint CHUNKS      = LINE_WIDTH / CHUNK_WIDTH,
    parameter hpdcache_uint CHUNK_IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [SET_W-1:0]       req_set_i,
    input  logic [WAYS-1:0]        req_way_i,
    input  logic                   line_valid_i,
    output logic                   line_pop_o,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic                   ram_req_o,
    input  logic                   ram_gnt_i,
    output logic [SET_W-1:0]       ram_set_o,
    output logic [CHUNK_IDX_W-1:0] ram_chunk_o,
    output logic [WAYS-1:0]        ram_way_o,
    output logic [CHUNK_WIDTH-1:0] ram_wdata_o,
    output logic                   done_valid_o,
    input  logic                   done_ready_i,
    output logic [SET_W-1:0]       done_set_o,
    output logic [WAYS-1:0]        done_way_o
);
    if (CHUNK_WIDTH == 0 || CHUNK_WIDTH > LINE_WIDTH || (LINE_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_cfg
        $error("hpdcache_refill_line_writer: CHUNK_WIDTH must be non-zero and divide LINE_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, WAIT_LINE, WRITE, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SET_W-1:0]       set_q, set_d;
    logic [WAYS-1:0]        way_q, way_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;
    logic [CHUNK_IDX_W-1:0] chunk_q, chunk_d;
    logic                   last_chunk;

    assign last_chunk  = hpdcache_uint'(chunk_q) == hpdcache_uint'(CHUNKS - 1);
    assign ram_set_o   = set_q;
    assign ram_way_o   = way_q;
    assign ram_chunk_o = chunk_q;
    assign ram_wdata_o = line_q[hpdcache_uint'(chunk_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
    assign done_set_o  = set_q;
    assign done_way_o  = way_q;

    always_comb begin
        state_d      = state_q;
        set_d        = set_q;
        way_d        = way_q;
        line_d       = line_q;
        chunk_d      = chunk_q;
        req_ready_o  = 1'b0;
        line_pop_o   = 1'b0;
        ram_req_o    = 1'b0;
        done_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                // gated so every control output reads 0 while reset is held
                req_ready_o = rst_ni;
                if (req_valid_i) begin
                    set_d   = req_set_i;
                    way_d   = req_way_i;
                    state_d = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                // head data is only valid in the pop cycle, so capture it here
                line_pop_o = line_valid_i;
                if (line_valid_i) begin
                    line_d  = line_i;
                    chunk_d = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ram_req_o = 1'b1;
                if (ram_gnt_i) begin
                    if (last_chunk) state_d = DONE;
                    else            chunk_d = chunk_q + CHUNK_IDX_W'(1);
                end
            end
            DONE: begin
                done_valid_o = 1'b1;
                if (done_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
            line_q  <= '0;
            chunk_q <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            line_q  <= line_d;
            chunk_q <= chunk_d;
        end
    end
endmodule

// File: tb/tb_hpdcache_refill_line_writer.sv
// tb_hpdcache_refill_line_writer: randomized self-checking bench for the refill line writer
module tb_hpdcache_refill_line_writer;
    logic         clk = 1'b0;
    logic         rst_ni;
    logic         req_valid;
    logic         req_ready;
    logic [6:0]   req_set;
    logic [3:0]   req_way;
    logic         line_valid;
    logic         line_pop;
    logic [511:0] line_data;
    logic         ram_req;
    logic         ram_gnt;
    logic [6:0]   ram_set;
    logic [1:0]   ram_chunk;
    logic [3:0]   ram_way;
    logic [127:0] ram_wdata;
    logic         done_valid;
    logic         done_ready;
    logic [6:0]   done_set;
    logic [3:0]   done_way;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hpdcache_refill_line_writer dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_set_i(req_set), .req_way_i(req_way),
        .line_valid_i(line_valid), .line_pop_o(line_pop), .line_i(line_data),
        .ram_req_o(ram_req), .ram_gnt_i(ram_gnt), .ram_set_o(ram_set), .ram_chunk_o(ram_chunk),
        .ram_way_o(ram_way), .ram_wdata_o(ram_wdata),
        .done_valid_o(done_valid), .done_ready_i(done_ready), .done_set_o(done_set), .done_way_o(done_way)
    );

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, line_pop, ram_req, done_valid, ram_set, ram_chunk, ram_way, ram_wdata, done_set, done_way} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b pop=%b req=%b done=%b set=%h chunk=%h way=%b data=%h, want all 0",
                     req_ready, line_pop, ram_req, done_valid, ram_set, ram_chunk, ram_way, ram_wdata);
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, line_pop, ram_req, done_valid} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_release: got ready/pop/req/done=%b, want 1000", {req_ready, line_pop, ram_req, done_valid});
        end
    endtask

    // One complete refill: request, optional line delay, chunk writes under a
    // grant pattern (bit i = grant in write cycle i, then always granted),
    // done held for ddly cycles before acceptance.
    task automatic run_line(input logic [6:0] s, input logic [3:0] w, input logic [511:0] ln,
                            input logic [31:0] gpat, input int glen, input int ldly,
                            input bit pre_valid, input int ddly);
        int c0, idx, gi, stalls;
        logic g;
        @(negedge clk);
        req_valid = 1'b1; req_set = s; req_way = w;
        line_valid = pre_valid; line_data = rand_line(); ram_gnt = 1'($urandom); done_ready = 1'b0;
        c0 = cyc;
        #1;
        n_cmp++;
        if ({req_ready, line_pop, ram_req, done_valid} !== 4'b1000) begin
            n_bad++;
            $display("FAIL idle_accept: got ready/pop/req/done=%b, want 1000", {req_ready, line_pop, ram_req, done_valid});
        end
        @(negedge clk);
        req_valid = 1'($urandom); req_set = 7'($urandom); req_way = 4'($urandom);
        for (int i = 0; i < ldly; i++) begin
            line_valid = 1'b0; ram_gnt = 1'($urandom);
            #1;
            n_cmp++;
            if ({req_ready, line_pop, ram_req, done_valid} !== 4'b0000) begin
                n_bad++;
                $display("FAIL wait_line: got ready/pop/req/done=%b, want 0000", {req_ready, line_pop, ram_req, done_valid});
            end
            @(negedge clk);
        end
        line_valid = 1'b1; line_data = ln;
        #1;
        n_cmp++;
        if ({req_ready, line_pop, ram_req, done_valid} !== 4'b0100) begin
            n_bad++;
            $display("FAIL pop: got ready/pop/req/done=%b, want 0100", {req_ready, line_pop, ram_req, done_valid});
        end
        @(negedge clk);
        line_valid = 1'($urandom); line_data = rand_line(); req_valid = 1'($urandom);
        idx = 0; gi = 0; stalls = 0;
        while (idx < 4 && gi < 64) begin
            g = (gi < glen) ? gpat[gi] : 1'b1;
            ram_gnt = g; gi++;
            #1;
            n_cmp++;
            if ({ram_req, ram_chunk, ram_set, ram_way, ram_wdata, line_pop, done_valid, req_ready}
                !== {1'b1, idx[1:0], s, w, ln[idx*128 +: 128], 3'b000}) begin
                n_bad++;
                $display("FAIL write: got req=%b chunk=%0d set=%h way=%b data=%h pop=%b done=%b ready=%b, want req=1 chunk=%0d set=%h way=%b data=%h",
                         ram_req, ram_chunk, ram_set, ram_way, ram_wdata, line_pop, done_valid, req_ready,
                         idx, s, w, ln[idx*128 +: 128]);
            end
            if (g) idx++; else stalls++;
            @(negedge clk);
        end
        if (idx < 4) begin
            n_cmp++; n_bad++;
            $display("FAIL write_timeout: got %0d chunks granted, want 4", idx);
        end
        ram_gnt = 1'b1; line_valid = 1'b1; req_valid = 1'b1;
        for (int i = 0; i <= ddly; i++) begin
            done_ready = (i == ddly);
            #1;
            n_cmp++;
            if ({done_valid, done_set, done_way, req_ready, ram_req, line_pop} !== {1'b1, s, w, 3'b000}) begin
                n_bad++;
                $display("FAIL done_hold: got valid=%b set=%h way=%b ready=%b req=%b pop=%b, want valid=1 set=%h way=%b ready/req/pop=0",
                         done_valid, done_set, done_way, req_ready, ram_req, line_pop, s, w);
            end
            if (i == 0) begin
                n_cmp++;
                if (cyc - c0 !== 6 + ldly + stalls) begin
                    n_bad++;
                    $display("FAIL latency: got %0d cycles req->done, want %0d", cyc - c0, 6 + ldly + stalls);
                end
            end
            @(negedge clk);
        end
        done_ready = 1'b0; req_valid = 1'b0; line_valid = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, done_valid, ram_req, line_pop} !== 4'b1000) begin
            n_bad++;
            $display("FAIL back_idle: got ready/done/req/pop=%b, want 1000", {req_ready, done_valid, ram_req, line_pop});
        end
    endtask

    task automatic test_reset_mid_line();
        logic [511:0] ln;
        ln = rand_line();
        @(negedge clk);
        req_valid = 1'b1; req_set = 7'h2a; req_way = 4'b0010; ram_gnt = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; line_valid = 1'b1; line_data = ln;
        @(negedge clk);
        line_valid = 1'b0; ram_gnt = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ram_req, ram_chunk} !== 3'b110) begin
            n_bad++;
            $display("FAIL mid_line: got req=%b chunk=%0d, want req=1 chunk=2", ram_req, ram_chunk);
        end
        #1 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, line_pop, ram_req, done_valid, ram_set, ram_chunk, ram_way, ram_wdata, done_set, done_way} !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got ready=%b req=%b done=%b set=%h chunk=%0d way=%b data=%h, want all 0",
                     req_ready, ram_req, done_valid, ram_set, ram_chunk, ram_way, ram_wdata);
        end
        @(negedge clk);
        rst_ni = 1'b1; ram_gnt = 1'b0;
        run_line(7'h33, 4'b1000, rand_line(), 32'h0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        req_valid = 1'b0; req_set = '0; req_way = '0; line_valid = 1'b0; line_data = '0;
        ram_gnt = 1'b0; done_ready = 1'b0;
        test_reset();
        run_line(7'h15, 4'b0100, {128'd3, 128'd2, 128'd1, 128'd0}, 32'h0, 0, 0, 1'b0, 0);
        run_line(7'h15, 4'b0100, rand_line(), 32'h69, 7, 0, 1'b0, 0);
        run_line(7'h01, 4'b0001, rand_line(), 32'h0, 0, 0, 1'b1, 0);
        run_line(7'h7f, 4'b1000, rand_line(), 32'h0, 0, 5, 1'b0, 0);
        run_line(7'h40, 4'b0010, rand_line(), 32'h0, 0, 0, 1'b0, 3);
        test_reset_mid_line();
        for (int k = 0; k < 25; k++)
            run_line(7'($urandom), 4'b0001 << $urandom_range(3), rand_line(), $urandom, 32,
                     $urandom_range(3), 1'($urandom), $urandom_range(3));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
